// File: rtl/seq_shifter_pkg.sv
// Shared constants for the multi-cycle shift/rotate unit: operation codes and FSM state encoding.
package seq_shifter_pkg;

   localparam logic [1:0] MODE_ASR = 2'b00;
   localparam logic [1:0] MODE_LSR = 2'b01;
   localparam logic [1:0] MODE_LSL = 2'b10;
   localparam logic [1:0] MODE_ROL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result bundle between the operand registers (master) and the shifter (slave).
interface seq_shifter_if #(
   parameter int WIDTH = 17,
   parameter int AMT_W = 5
);
   logic             start;
   logic [WIDTH-1:0] in;
   logic [AMT_W-1:0] amt;
   logic [1:0]       mode;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             carry;
   logic             zero;

   modport master (
      output start, in, amt, mode,
      input  busy, done, out, carry, zero
   );

   modport slave (
      input  start, in, amt, mode,
      output busy, done, out, carry, zero
   );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// One 1-bit shift/rotate step, built as a per-bit and/or mux like the old combinational shifter.
module shift_step
   import seq_shifter_pkg::*;
#(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] stepped,
   output logic             shifted_out
);

   logic sel_left;
   logic msb_fill;
   logic lsb_fill;

   assign sel_left = (mode == MODE_LSL) | (mode == MODE_ROL);
   assign msb_fill = (mode == MODE_ASR) & data[WIDTH-1];
   assign lsb_fill = (mode == MODE_ROL) & data[WIDTH-1];

   assign stepped[0]       = (sel_left & lsb_fill)         | (~sel_left & data[1]);
   assign stepped[WIDTH-1] = (sel_left & data[WIDTH-2])    | (~sel_left & msb_fill);

   for (genvar i = 1; i < WIDTH - 1; i++) begin : g_mid
      assign stepped[i] = (sel_left & data[i-1]) | (~sel_left & data[i+1]);
   end

   assign shifted_out = (sel_left & data[WIDTH-1]) | (~sel_left & data[0]);

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit per clock under a start/busy/done handshake.
// state    | meaning
// ST_IDLE  | waiting for a request
// ST_SHIFT | one 1-bit step per cycle, counter counting down
// ST_DONE  | result and flags presented for one cycle; start here is accepted back-to-back
module seq_shifter
   import seq_shifter_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int AMT_W = 5
) (
   input  logic           clk,
   input  logic           rst,
   seq_shifter_if.slave   bus
);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [AMT_W-1:0] cnt;
   logic [1:0]       mode_q;
   logic             carry_q;
   logic             zero_q;
   logic             done_q;

   logic [WIDTH-1:0] step_data;
   logic             step_bit;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data        (work),
      .mode        (mode_q),
      .stepped     (step_data),
      .shifted_out (step_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         work    <= '0;
         cnt     <= '0;
         mode_q  <= MODE_ASR;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  work    <= bus.in;
                  cnt     <= bus.amt;
                  mode_q  <= bus.mode;
                  carry_q <= 1'b0;
                  if (bus.amt == '0) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                     zero_q <= (bus.in == '0);
                  end else begin
                     state <= ST_SHIFT;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               work    <= step_data;
               carry_q <= step_bit;
               cnt     <= cnt - AMT_W'(1);
               // Terminal count: this step is the last, so flags are computed from the stepped word.
               if (cnt == AMT_W'(1)) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                  zero_q <= (step_data == '0);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy  = (state == ST_SHIFT);
   assign bus.done  = done_q;
   assign bus.out   = work;
   assign bus.carry = carry_q;
   assign bus.zero  = zero_q;

endmodule
